// File: rtl/sag4fun_sched.sv
// sag4fun_sched: two-requester round-robin front end for the iterative SAG gather/scatter engine.
// Define SAG4FUN_SCHED_MASKCACHE_EN to remember the last loaded mask and skip redundant load passes.
module sag4fun_sched #(
    parameter int XLEN = 32  // 32 or 64 only; must match the engine instance
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_inv,
    input  logic            req0_msk,
    input  logic [XLEN-1:0] req0_data,
    input  logic [XLEN-1:0] req0_mask,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_inv,
    input  logic            req1_msk,
    input  logic [XLEN-1:0] req1_data,
    input  logic [XLEN-1:0] req1_mask,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_data,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_data,
    output logic            eng_ctrl_start,
    output logic            eng_ctrl_inv,
    output logic            eng_ctrl_msk,
    output logic            eng_ctrl_ldm,
    input  logic            eng_ctrl_ready,
    output logic [XLEN-1:0] eng_in_data,
    input  logic [XLEN-1:0] eng_out_data
);

    typedef enum logic [2:0] {IDLE, LOAD, LWAIT, RUN, RWAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic            port_reg, inv_reg, msk_reg, last_reg;
    logic [XLEN-1:0] data_reg, mask_reg, result_reg;

    logic [1:0]      req_valid, req_inv, req_msk, req_ready;
    logic [1:0]      rsp_valid_vec, rsp_ready_vec;
    logic [XLEN-1:0] req_data [2];
    logic [XLEN-1:0] req_mask [2];
    logic [XLEN-1:0] rsp_data_vec [2];
    logic            grant, fire, hit;

    assign req_valid     = {req1_valid, req0_valid};
    assign req_inv       = {req1_inv, req0_inv};
    assign req_msk       = {req1_msk, req0_msk};
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};
    assign req_data[0]   = req0_data;
    assign req_data[1]   = req1_data;
    assign req_mask[0]   = req0_mask;
    assign req_mask[1]   = req1_mask;

    // Contention goes to the port not served last; otherwise to whichever port is asking.
    assign grant = (req_valid == 2'b11) ? ~last_reg : req_valid[1];
    assign fire  = req_valid[grant] && req_ready[grant];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi]     = (state_reg == IDLE) && !reset && (grant == 1'(gi))
                                       && !rsp_valid_vec[gi];
            assign rsp_valid_vec[gi] = (state_reg == RESP) && (port_reg == 1'(gi));
            assign rsp_data_vec[gi]  = rsp_valid_vec[gi] ? result_reg : '0;
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_data  = rsp_data_vec[0];
    assign rsp1_data  = rsp_data_vec[1];

`ifdef SAG4FUN_SCHED_MASKCACHE_EN
    logic [XLEN-1:0] mask_q_reg;
    logic            mask_vld_reg;

    assign hit = mask_vld_reg && (req_mask[grant] == mask_q_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q_reg   <= '0;
            mask_vld_reg <= 1'b0;
        end else if (state_reg == LWAIT && eng_ctrl_ready) begin
            mask_q_reg   <= mask_reg;
            mask_vld_reg <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            last_reg   <= 1'b1;
            port_reg   <= 1'b0;
            inv_reg    <= 1'b0;
            msk_reg    <= 1'b0;
            data_reg   <= '0;
            mask_reg   <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && fire) begin
                port_reg <= grant;
                inv_reg  <= req_inv[grant];
                msk_reg  <= req_msk[grant];
                data_reg <= req_data[grant];
                mask_reg <= req_mask[grant];
            end
            // Scatter post-masking happens here because the engine ignores ctrl_msk.
            if (state_reg == RWAIT && eng_ctrl_ready)
                result_reg <= (msk_reg && inv_reg) ? (eng_out_data & mask_reg) : eng_out_data;
            if (state_reg == RESP && rsp_ready_vec[port_reg])
                last_reg <= port_reg;
        end
    end

    always_comb begin
        state_next     = state_reg;
        eng_ctrl_start = 1'b0;
        eng_ctrl_inv   = 1'b0;
        eng_ctrl_msk   = 1'b0;
        eng_ctrl_ldm   = 1'b0;
        eng_in_data    = '0;
        case (state_reg)
            IDLE: begin
                if (fire)
                    state_next = hit ? RUN : LOAD;
            end
            LOAD: begin
                eng_ctrl_start = 1'b1;
                eng_ctrl_ldm   = 1'b1;
                eng_in_data    = mask_reg;
                state_next     = LWAIT;
            end
            LWAIT: begin
                if (eng_ctrl_ready)
                    state_next = RUN;
            end
            RUN: begin
                eng_ctrl_start = 1'b1;
                eng_ctrl_inv   = inv_reg;
                eng_ctrl_msk   = msk_reg;
                eng_in_data    = (msk_reg && !inv_reg) ? (data_reg & mask_reg) : data_reg;
                state_next     = RWAIT;
            end
            RWAIT: begin
                if (eng_ctrl_ready)
                    state_next = RESP;
            end
            RESP: begin
                if (rsp_ready_vec[port_reg])
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sag4fun_sched.sv
// Bench for sag4fun_sched: behavioural SAG engine (latency L), per-port scoreboards, directed steps.
// Latency/load expectations follow SAG4FUN_SCHED_MASKCACHE_EN when it is defined.
module tb_sag4fun_sched;
    localparam int XLEN = 32;
    localparam int L    = 5;
`ifdef SAG4FUN_SCHED_MASKCACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int LAT_MISS = 2 * L + 3;
    localparam int LAT_HIT  = L + 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            req0_valid = 1'b0, req0_inv = 1'b0, req0_msk = 1'b0;
    logic            req1_valid = 1'b0, req1_inv = 1'b0, req1_msk = 1'b0;
    logic [XLEN-1:0] req0_data = '0, req0_mask = '0, req1_data = '0, req1_mask = '0;
    logic            req0_ready, req1_ready;
    logic            rsp0_valid, rsp1_valid;
    logic            rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [XLEN-1:0] rsp0_data, rsp1_data;
    logic            eng_ctrl_start, eng_ctrl_inv, eng_ctrl_msk, eng_ctrl_ldm, eng_ctrl_ready;
    logic [XLEN-1:0] eng_in_data, eng_out_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int loads = 0;

    sag4fun_sched #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_inv(req0_inv),
        .req0_msk(req0_msk), .req0_data(req0_data), .req0_mask(req0_mask),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_inv(req1_inv),
        .req1_msk(req1_msk), .req1_data(req1_data), .req1_mask(req1_mask),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .eng_ctrl_start(eng_ctrl_start), .eng_ctrl_inv(eng_ctrl_inv),
        .eng_ctrl_msk(eng_ctrl_msk), .eng_ctrl_ldm(eng_ctrl_ldm),
        .eng_ctrl_ready(eng_ctrl_ready), .eng_in_data(eng_in_data),
        .eng_out_data(eng_out_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] compress(input logic [XLEN-1:0] d, input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r = '0;
        int j = 0;
        for (int i = 0; i < XLEN; i++)
            if (m[i]) begin
                r[j] = d[i];
                j++;
            end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] expand(input logic [XLEN-1:0] d, input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r = '0;
        int j = 0;
        for (int i = 0; i < XLEN; i++)
            if (m[i]) begin
                r[i] = d[j];
                j++;
            end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] model(input logic inv, input logic msk,
                                              input logic [XLEN-1:0] d, input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        if (inv) begin
            r = expand(d, m);
            if (msk) r = r & m;
        end else begin
            r = compress(msk ? (d & m) : d, m);
        end
        return r;
    endfunction

    // Behavioural engine: swap config loaded on ldm, result pulses out L cycles after start.
    logic [L-1:0]    eng_pipe_v;
    logic [XLEN-1:0] eng_pipe_d [L];
    logic [XLEN-1:0] eng_cfg;

    always @(posedge clock) begin
        if (reset) begin
            eng_pipe_v <= '0;
            eng_cfg    <= '0;
        end else begin
            eng_pipe_v <= {eng_pipe_v[L-2:0], eng_ctrl_start};
            for (int i = L - 1; i > 0; i--) eng_pipe_d[i] <= eng_pipe_d[i-1];
            eng_pipe_d[0] <= '0;
            if (eng_ctrl_start) begin
                if (eng_ctrl_ldm) eng_cfg <= eng_in_data;
                else eng_pipe_d[0] <= eng_ctrl_inv ? expand(eng_in_data, eng_cfg)
                                                    : compress(eng_in_data, eng_cfg);
            end
        end
    end
    assign eng_ctrl_ready = eng_pipe_v[L-1];
    assign eng_out_data   = eng_ctrl_ready ? eng_pipe_d[L-1] : 32'hDEAD_BEEF;

    // Scoreboard monitor: push expectations at accept, pop at response handshake.
    logic [XLEN-1:0] q0 [$];
    logic [XLEN-1:0] q1 [$];
    int              grants [$];
    logic [XLEN-1:0] cur_in = '0, cur_mask = '0;
    logic            cur_inv = 1'b0;
    logic [XLEN-1:0] sb_exp;

    always @(negedge clock) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req0_valid && req0_ready) begin
                q0.push_back(model(req0_inv, req0_msk, req0_data, req0_mask));
                grants.push_back(0);
                cur_inv  = req0_inv;
                cur_mask = req0_mask;
                cur_in   = (req0_msk && !req0_inv) ? (req0_data & req0_mask) : req0_data;
            end
            if (req1_valid && req1_ready) begin
                q1.push_back(model(req1_inv, req1_msk, req1_data, req1_mask));
                grants.push_back(1);
                cur_inv  = req1_inv;
                cur_mask = req1_mask;
                cur_in   = (req1_msk && !req1_inv) ? (req1_data & req1_mask) : req1_data;
            end
            if (eng_ctrl_start) begin
                if (eng_ctrl_ldm) begin
                    loads++;
                    check("load_in_data", eng_in_data, cur_mask);
                end else begin
                    check("run_in_data", eng_in_data, cur_in);
                    check("run_inv", eng_ctrl_inv, cur_inv);
                end
            end
            if (rsp0_valid && rsp0_ready) begin
                check("rsp0_expected", q0.size() != 0, 1'b1);
                sb_exp = (q0.size() != 0) ? q0.pop_front() : 'x;
                check("rsp0_sb", rsp0_data, sb_exp);
            end
            if (rsp1_valid && rsp1_ready) begin
                check("rsp1_expected", q1.size() != 0, 1'b1);
                sb_exp = (q1.size() != 0) ? q1.pop_front() : 'x;
                check("rsp1_sb", rsp1_data, sb_exp);
            end
        end
    end

    task automatic drive(input bit p, input bit v, input bit inv, input bit msk,
                         input logic [XLEN-1:0] d, input logic [XLEN-1:0] m);
        if (p) begin
            req1_valid = v; req1_inv = inv; req1_msk = msk; req1_data = d; req1_mask = m;
        end else begin
            req0_valid = v; req0_inv = inv; req0_msk = msk; req0_data = d; req0_mask = m;
        end
    endtask

    task automatic run_op(input bit p, input bit inv, input bit msk,
                          input logic [XLEN-1:0] d, input logic [XLEN-1:0] m,
                          input logic [XLEN-1:0] exp_in, input logic [XLEN-1:0] exp_data,
                          input int exp_lat, input int exp_loads, input string tag);
        int t0 = 0, l0 = 0;
        bit ok = 0;
        logic [XLEN-1:0] run_in = 'x;
        @(posedge clock); #1;
        drive(p, 1'b1, inv, msk, d, m);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (p ? req1_ready : req0_ready) begin ok = 1; break; end
        end
        check({tag, "_accept"}, ok, 1'b1);
        t0 = cyc;
        l0 = loads;
        @(posedge clock); #1;
        drive(p, 1'b0, inv, msk, d, m);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (eng_ctrl_start && !eng_ctrl_ldm) run_in = eng_in_data;
            if (p ? rsp1_valid : rsp0_valid) begin ok = 1; break; end
        end
        check({tag, "_rsp_seen"}, ok, 1'b1);
        check({tag, "_latency"}, cyc - t0, exp_lat);
        check({tag, "_loads"}, loads - l0, exp_loads);
        check({tag, "_eng_in"}, run_in, exp_in);
        check({tag, "_data"}, (p ? rsp1_data : rsp0_data), exp_data);
        $display("op %s: port=%0d inv=%0d msk=%0d data=%h mask=%h -> rsp=%h latency=%0d",
                 tag, p, inv, msk, d, m, (p ? rsp1_data : rsp0_data), cyc - t0);
    endtask

    initial begin
        int g0;
        bit ok;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_start", eng_ctrl_start, 1'b0);
        check("rst_in_data", eng_in_data, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Round-robin with both ports permanently valid
        grants.delete();
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h00FF_00FF);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'hF0F0_F0F0);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (grants.size() >= 4) begin ok = 1; break; end
        end
        check("rr_four_grants", ok, 1'b1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rr_grant_order", (grants.size() > i) ? grants[i] : -1, i % 2);
            $display("rr grant %0d -> port %0d", i, (grants.size() > i) ? grants[i] : -1);
        end
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (q0.size() == 0 && q1.size() == 0) begin ok = 1; break; end
        end
        check("rr_drained", ok, 1'b1);

        // Directed ops: miss, cached/uncached repeat, unmasked gather
        run_op(1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 32'h0000_FF00,
               LAT_MISS, 1, "gather_msk");
        run_op(1'b0, 1'b1, 1'b1, 32'h0000_FF00, 32'h0F0F_0F0F, 32'h0000_FF00, 32'h0F0F_0000,
               CACHE ? LAT_HIT : LAT_MISS, CACHE ? 0 : 1, "scatter_msk");
        run_op(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFFF, 32'h0000_000F,
               LAT_MISS, 1, "gather_nomsk");

        // Backpressure on port 0 while both ports request
        @(posedge clock); #1;
        rsp0_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A, 32'h0F0F_0F0F);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (req0_ready) begin ok = 1; break; end
        end
        check("stall_accept", ok, 1'b1);
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00FF, 32'h3333_CCCC);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (rsp0_valid) begin ok = 1; break; end
        end
        check("stall_rsp_seen", ok, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("stall_valid", rsp0_valid, 1'b1);
            check("stall_data", rsp0_data, 32'h0000_55AA);
            check("stall_req0_ready", req0_ready, 1'b0);
            check("stall_req1_ready", req1_ready, 1'b0);
        end
        $display("stall: rsp0 held 20 cycles data=%h", rsp0_data);
        g0 = grants.size();
        @(posedge clock); #1;
        rsp0_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (grants.size() > g0) begin ok = 1; break; end
        end
        check("stall_next_grant_seen", ok, 1'b1);
        check("stall_next_grant", grants[$], 1);
        @(posedge clock); #1;
        req1_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (grants.size() > g0 + 1) begin ok = 1; break; end
        end
        check("stall_port0_regrant_seen", ok, 1'b1);
        check("stall_port0_regrant", grants[$], 0);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (q0.size() == 0 && q1.size() == 0) begin ok = 1; break; end
        end
        check("stall_drained", ok, 1'b1);

        // Reset during RWAIT drops the op and invalidates the mask cache
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (req0_ready) begin ok = 1; break; end
        end
        check("rst_op_accept", ok, 1'b1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (eng_ctrl_start && !eng_ctrl_ldm) begin ok = 1; break; end
        end
        check("rst_op_run_seen", ok, 1'b1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("midrst_rsp0_valid", rsp0_valid, 1'b0);
        check("midrst_rsp1_valid", rsp1_valid, 1'b0);
        check("midrst_start", eng_ctrl_start, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("postrst_idle_ready", req0_ready, 1'b1);
        check("postrst_rsp0_valid", rsp0_valid, 1'b0);
        run_op(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1234_5678, 32'h0000_2468,
               LAT_MISS, 1, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
